mem_bus_arbiter: RTL and testbench

Shares one memory slave port between the instruction-fetch master (ibus, read-only) and the load/store master (dbus, read/write). Requests are Avalon-MM style with waitrequest and pipelined readdatavalid responses. The block sits between the core and the memory. Its ibus_waitrequest output is the fetch stall seen by hazard detection. Arbitration gives dbus priority, with a starvation limit, and tracks outstanding reads so responses return to the right master.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_id_fifo.sv | 65 ++++++
 rtl/mem_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the ibus/dbus memory arbiter.
// No logic; owner encoding and response-source ids only.
// N/A: no handshake of its own.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IBUS = 2'd1,
        OWNER_DBUS = 2'd2
    } owner_e;

    // Source id recorded per accepted read so responses can be routed back
    localparam logic ID_IBUS = 1'b0;
    localparam logic ID_DBUS = 1'b1;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order 1-bit FIFO of read source ids awaiting a response.
// Head valid combinationally; push/pop take effect on the next rising clk.
// A push while full is taken only if a pop happens in the same cycle.
module mem_arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_din,
    input  logic          i_pop,
    output logic          o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_head  = r_mem[r_rd_ptr];

    // At full occupancy the slot being popped is the one the push overwrites
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    // Pointer, storage and occupancy update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Avalon-MM slave between ibus (fetch) and dbus (load/store).
// Zero added latency: requests and responses pass combinationally.
// Losing or read-blocked master sees waitrequest=1; owner locks while slave stalls.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int DBUS_LIMIT      = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ibus_read,
    input  logic [AW-1:0]   ibus_address,
    output logic            ibus_waitrequest,
    output logic [DW-1:0]   ibus_readdata,
    output logic            ibus_readdatavalid,
    input  logic            dbus_read,
    input  logic            dbus_write,
    input  logic [AW-1:0]   dbus_address,
    input  logic [DW-1:0]   dbus_writedata,
    input  logic [DW/8-1:0] dbus_byteenable,
    output logic            dbus_waitrequest,
    output logic [DW-1:0]   dbus_readdata,
    output logic            dbus_readdatavalid,
    output logic            mem_read,
    output logic            mem_write,
    output logic [AW-1:0]   mem_address,
    output logic [DW-1:0]   mem_writedata,
    output logic [DW/8-1:0] mem_byteenable,
    input  logic            mem_waitrequest,
    input  logic [DW-1:0]   mem_readdata,
    input  logic            mem_readdatavalid,
    output logic            resp_error
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(DBUS_LIMIT + 1);

    owner_e          r_owner;
    logic [SW-1:0]   r_starve;
    logic            r_resp_error;
    owner_e          w_sel;
    logic            w_starved;
    logic            w_rd_ok;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_head;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;

    assign w_starved = (r_starve == SW'(DBUS_LIMIT));
    assign w_pop     = mem_readdatavalid & ~w_empty;
    // A response in this cycle frees a slot for a read issued in the same cycle
    assign w_rd_ok   = ~w_full | w_pop;

    // Winner: locked owner if any, else dbus unless ibus has been starved
    always_comb begin
        w_sel = r_owner;
        if (r_owner == OWNER_NONE) begin
            if ((dbus_read || dbus_write) && !(w_starved && ibus_read)) begin
                w_sel = OWNER_DBUS;
            end else if (ibus_read) begin
                w_sel = OWNER_IBUS;
            end
        end
    end

    // Steer the winner's request onto the slave port
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_byteenable = '0;
        case (w_sel)
            OWNER_IBUS: begin
                mem_read       = ibus_read & w_rd_ok;
                mem_address    = ibus_address;
                mem_byteenable = '1;
            end
            OWNER_DBUS: begin
                mem_read       = dbus_read & w_rd_ok;
                mem_write      = dbus_write;
                mem_address    = dbus_address;
                mem_byteenable = dbus_byteenable;
            end
            default: ;
        endcase
    end

    assign mem_writedata    = dbus_writedata;
    assign w_accept         = (mem_read | mem_write) & ~mem_waitrequest;
    assign ibus_waitrequest = ~(w_accept && (w_sel == OWNER_IBUS));
    assign dbus_waitrequest = ~(w_accept && (w_sel == OWNER_DBUS));
    assign w_push           = mem_read & ~mem_waitrequest;

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   ((w_sel == OWNER_DBUS) ? ID_DBUS : ID_IBUS),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign ibus_readdata      = mem_readdata;
    assign dbus_readdata      = mem_readdata;
    assign ibus_readdatavalid = w_pop & (w_head == ID_IBUS);
    assign dbus_readdatavalid = w_pop & (w_head == ID_DBUS);
    assign resp_error         = r_resp_error;

    // Owner lock, starvation counter and sticky spurious-response flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= OWNER_NONE;
            r_starve     <= '0;
            r_resp_error <= 1'b0;
        end else begin
            // Hold the winner only while its presented request is stalled
            r_owner <= ((mem_read | mem_write) & mem_waitrequest) ? w_sel : OWNER_NONE;

            if (!ibus_read || (w_accept && (w_sel == OWNER_IBUS))) begin
                r_starve <= '0;
            end else if (w_accept && (w_sel == OWNER_DBUS) && !w_starved) begin
                r_starve <= r_starve + 1'b1;
            end

            if (mem_readdatavalid && (w_count == '0)) begin
                r_resp_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: combinational arbitration table plus
// multi-cycle sequences for locking, starvation, read blocking and routing.
// Inputs driven on the falling edge, outputs sampled 1 ns later.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ibus_read = 1'b0;
    logic [31:0] ibus_address = '0;
    logic        ibus_waitrequest;
    logic [31:0] ibus_readdata;
    logic        ibus_readdatavalid;
    logic        dbus_read = 1'b0;
    logic        dbus_write = 1'b0;
    logic [31:0] dbus_address = '0;
    logic [31:0] dbus_writedata = '0;
    logic [3:0]  dbus_byteenable = '0;
    logic        dbus_waitrequest;
    logic [31:0] dbus_readdata;
    logic        dbus_readdatavalid;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] mem_readdata = '0;
    logic        mem_readdatavalid = 1'b0;
    logic        resp_error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .AW (32), .DW (32), .MAX_OUTSTANDING (2), .DBUS_LIMIT (4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ibus_read          (ibus_read),
        .ibus_address       (ibus_address),
        .ibus_waitrequest   (ibus_waitrequest),
        .ibus_readdata      (ibus_readdata),
        .ibus_readdatavalid (ibus_readdatavalid),
        .dbus_read          (dbus_read),
        .dbus_write         (dbus_write),
        .dbus_address       (dbus_address),
        .dbus_writedata     (dbus_writedata),
        .dbus_byteenable    (dbus_byteenable),
        .dbus_waitrequest   (dbus_waitrequest),
        .dbus_readdata      (dbus_readdata),
        .dbus_readdatavalid (dbus_readdatavalid),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_address        (mem_address),
        .mem_writedata      (mem_writedata),
        .mem_byteenable     (mem_byteenable),
        .mem_waitrequest    (mem_waitrequest),
        .mem_readdata       (mem_readdata),
        .mem_readdatavalid  (mem_readdatavalid),
        .resp_error         (resp_error)
    );

    typedef struct packed {
        logic        ir, dr, dw, mw;
        logic [31:0] ia, da;
        logic [3:0]  be;
        logic        e_mr, e_mw, e_iw, e_dw, e_chk;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mkv(input logic ir, dr, dw, mw,
                                 input logic [31:0] ia, da, input logic [3:0] be,
                                 input logic e_mr, e_mw, e_iw, e_dw, e_chk,
                                 input logic [31:0] e_addr, input logic [3:0] e_be);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dw = dw; v.mw = mw;
        v.ia = ia; v.da = da; v.be = be;
        v.e_mr = e_mr; v.e_mw = e_mw; v.e_iw = e_iw; v.e_dw = e_dw; v.e_chk = e_chk;
        v.e_addr = e_addr; v.e_be = e_be;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ibus_read = 1'b0; dbus_read = 1'b0; dbus_write = 1'b0;
        mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0;
    endtask

    // Asynchronous reset pulse while clk is low
    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        string tag;
        string acc;
        string exp_acc;

        vecs[0] = mkv(0,0,0,0, 32'h0,   32'h0,   4'h0, 0,0,1,1, 0, 32'h0,   4'h0);
        vecs[1] = mkv(1,0,0,0, 32'h100, 32'h200, 4'h3, 1,0,0,1, 1, 32'h100, 4'hF);
        vecs[2] = mkv(1,0,0,1, 32'h104, 32'h200, 4'h3, 1,0,1,1, 1, 32'h104, 4'hF);
        vecs[3] = mkv(0,1,0,0, 32'h100, 32'h208, 4'h3, 1,0,1,0, 1, 32'h208, 4'h3);
        vecs[4] = mkv(0,0,1,0, 32'h100, 32'h20C, 4'hC, 0,1,1,0, 1, 32'h20C, 4'hC);
        vecs[5] = mkv(1,1,0,0, 32'h100, 32'h210, 4'h1, 1,0,1,0, 1, 32'h210, 4'h1);
        vecs[6] = mkv(1,0,1,0, 32'h100, 32'h214, 4'h8, 0,1,1,0, 1, 32'h214, 4'h8);
        vecs[7] = mkv(1,1,0,1, 32'h100, 32'h218, 4'hF, 1,0,1,1, 1, 32'h218, 4'hF);

        // Reset state, sampled while reset is held
        @(negedge clk);
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_ibus_wait", ibus_waitrequest, 1);
        chk("rst_dbus_wait", dbus_waitrequest, 1);
        chk("rst_resp_error", resp_error, 0);
        chk("rst_ibus_rdv", ibus_readdatavalid, 0);
        chk("rst_dbus_rdv", dbus_readdatavalid, 0);

        // Arbitration table from idle state; no clock edge between apply and check
        for (int i = 0; i < 8; i++) begin
            do_reset();
            ibus_read = vecs[i].ir; dbus_read = vecs[i].dr; dbus_write = vecs[i].dw;
            mem_waitrequest = vecs[i].mw;
            ibus_address = vecs[i].ia; dbus_address = vecs[i].da; dbus_byteenable = vecs[i].be;
            #1;
            tag = $sformatf("vec%0d", i);
            chk({tag, "_mem_read"}, mem_read, vecs[i].e_mr);
            chk({tag, "_mem_write"}, mem_write, vecs[i].e_mw);
            chk({tag, "_ibus_wait"}, ibus_waitrequest, vecs[i].e_iw);
            chk({tag, "_dbus_wait"}, dbus_waitrequest, vecs[i].e_dw);
            if (vecs[i].e_chk) begin
                chk({tag, "_mem_addr"}, mem_address, vecs[i].e_addr);
                chk({tag, "_mem_be"}, mem_byteenable, vecs[i].e_be);
            end
            idle_inputs();
        end

        // Single fetch with 1-cycle response
        do_reset();
        @(negedge clk);
        ibus_read = 1; ibus_address = 32'h100;
        #1;
        chk("fetch_addr", mem_address, 32'h100);
        chk("fetch_wait", ibus_waitrequest, 0);
        chk("fetch_rdv_early", ibus_readdatavalid, 0);
        @(negedge clk);
        ibus_read = 0; mem_readdatavalid = 1; mem_readdata = 32'hDEADBEEF;
        #1;
        chk("fetch_rdv", ibus_readdatavalid, 1);
        chk("fetch_data", ibus_readdata, 32'hDEADBEEF);
        chk("fetch_dbus_rdv", dbus_readdatavalid, 0);
        @(negedge clk);
        mem_readdatavalid = 0;

        // Both read with slave stall: dbus locked 4 cycles, then ibus; responses routed in order
        do_reset();
        ibus_address = 32'h300; dbus_address = 32'h400;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ibus_read = 1; dbus_read = 1; mem_waitrequest = (c < 3);
            #1;
            tag = $sformatf("lock%0d", c);
            chk({tag, "_addr"}, mem_address, 32'h400);
            chk({tag, "_dbus_wait"}, dbus_waitrequest, (c < 3) ? 1 : 0);
            chk({tag, "_ibus_wait"}, ibus_waitrequest, 1);
        end
        @(negedge clk);
        dbus_read = 0; mem_waitrequest = 0;
        #1;
        chk("lock_ibus_addr", mem_address, 32'h300);
        chk("lock_ibus_wait", ibus_waitrequest, 0);
        @(negedge clk);
        ibus_read = 0; mem_readdatavalid = 1; mem_readdata = 32'hA;
        #1;
        chk("route0_dbus_rdv", dbus_readdatavalid, 1);
        chk("route0_ibus_rdv", ibus_readdatavalid, 0);
        chk("route0_data", dbus_readdata, 32'hA);
        @(negedge clk);
        mem_readdata = 32'hB;
        #1;
        chk("route1_ibus_rdv", ibus_readdatavalid, 1);
        chk("route1_dbus_rdv", dbus_readdatavalid, 0);
        chk("route1_data", ibus_readdata, 32'hB);
        @(negedge clk);
        mem_readdatavalid = 0;

        // Starvation: continuous dbus writes vs waiting fetch
        do_reset();
        exp_acc = "DDDDID";
        acc = "";
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ibus_read = 1; dbus_write = 1;
            #1;
            if (!dbus_waitrequest && ibus_waitrequest) acc = {acc, "D"};
            else if (!ibus_waitrequest && dbus_waitrequest) acc = {acc, "I"};
            else acc = {acc, "x"};
        end
        n_tests++;
        if (acc != exp_acc) begin
            n_fail++;
            $display("FAIL starve_order: got %s expected %s", acc, exp_acc);
        end

        // Read blocking at MAX_OUTSTANDING; writes still pass; pop frees slot same cycle
        do_reset();
        ibus_address = 32'h500;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            ibus_read = 1;
            #1;
            chk($sformatf("blk_accept%0d", c), ibus_waitrequest, 0);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            dbus_write = (c == 1);
            #1;
            tag = $sformatf("blk_hold%0d", c);
            chk({tag, "_mem_read"}, mem_read, 0);
            chk({tag, "_ibus_wait"}, ibus_waitrequest, 1);
            if (c == 1) begin
                chk("blk_write_pass", mem_write, 1);
                chk("blk_write_wait", dbus_waitrequest, 0);
            end
        end
        @(negedge clk);
        dbus_write = 0; mem_readdatavalid = 1; mem_readdata = 32'h11;
        #1;
        chk("blk_release_mem_read", mem_read, 1);
        chk("blk_release_wait", ibus_waitrequest, 0);
        chk("blk_release_rdv", ibus_readdatavalid, 1);
        @(negedge clk);
        ibus_read = 0; mem_readdatavalid = 0;

        // Reset with a read outstanding, then a spurious response
        do_reset();
        @(negedge clk);
        ibus_read = 1;
        #1;
        chk("spur_accept", ibus_waitrequest, 0);
        @(negedge clk);
        ibus_read = 0;
        rst = 1;
        #2;
        rst = 0;
        chk("spur_err_before", resp_error, 0);
        @(negedge clk);
        mem_readdatavalid = 1; mem_readdata = 32'h55;
        #1;
        chk("spur_ibus_rdv", ibus_readdatavalid, 0);
        chk("spur_dbus_rdv", dbus_readdatavalid, 0);
        @(negedge clk);
        mem_readdatavalid = 0;
        #1;
        chk("spur_err_set", resp_error, 1);
        @(negedge clk);
        #1;
        chk("spur_err_sticky", resp_error, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
